commit_regfile_mp: RTL
======================

Name: commit_regfile_mp

Overview:
- Parametrised next-generation architectural register file for the commit stage, sized for multi-issue cores.
- Provides NUM_RD bypassed read ports and NUM_WB write-back ports with fixed priority between writers.
- Includes a per-register busy scoreboard (set at issue, cleared at write-back, bulk-cleared on flush).
- Includes a retired-instruction counter that advances by up to NUM_WB per cycle.
- Sits between the issue/decode stage (reads, busy lookup) and the write-back/commit stage (writes, retire).

Parameters:
- XLEN, 64, data width of each register.
- NREG, 32, number of architectural registers; must be a power of two, at least 2.
- AW, $clog2(NREG), register address width (derived).
- NUM_RD, 2, number of read ports.
- NUM_WB, 2, number of write-back/commit ports; port index i > j has priority.
- CNT_W, 64, retired-instruction counter width.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*AW  read addresses, port k in bits [k*AW +: AW]
- rd_data  out  NUM_RD*XLEN  bypassed read data
- rd_busy  out  NUM_RD  scoreboard busy after bypass
- issue_valid  in  1  an instruction with a destination is issued this cycle
- issue_rd  in  AW  destination of the issued instruction
- flush  in  1  pipeline flush; clears all busy bits
- wb_valid  in  NUM_WB  per-port write enable
- wb_addr  in  NUM_WB*AW  per-port destination
- wb_data  in  NUM_WB*XLEN  per-port data
- commit_valid  in  NUM_WB  per-port instruction retired (independent of wb_valid)
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset is decided as: reset reset, synchronous, active-high; clock clock.
- State cleared on reset:
  - all registers 0;
  - all busy bits 0;
  - instret 0.
- Outputs during and after reset: rd_data 0, rd_busy 0 (reads are combinational over cleared state).
- Register 0 is hardwired:
  - reads always return 0 and busy 0;
  - writes to addr 0 are dropped;
  - issue to addr 0 sets nothing.
- Write timing: on each clock edge (not in reset), for each valid wb port with addr != 0, the register takes wb_data.
  - Same-address collision in one cycle: the highest-index port wins.
- Read path (combinational, 0-cycle):
  - rd_data[k] = data of the highest-index wb port with wb_valid, wb_addr == rd_addr[k] and addr != 0;
  - otherwise the stored register value.
- Busy scoreboard, next-state per register r != 0:
  - set if issue_valid and issue_rd == r and !flush;
  - else cleared if any wb_valid port targets r, or flush;
  - else held.
  - Simultaneous issue and write-back to the same r: busy ends set (the new producer owns r); the register data still takes the wb value.
  - flush overrides issue: all busy bits become 0 on that edge.
- rd_busy[k] = busy[rd_addr[k]] & ~(any wb_valid port targeting rd_addr[k] this cycle).
  - A same-cycle issue does not raise rd_busy until the next cycle.
- instret: on each edge, instret += popcount(commit_valid), modulo 2^CNT_W (wraps silently).
  - popcount width is $clog2(NUM_WB+1), zero-extended to CNT_W.
- Reset mid-operation overrides every other input on that edge.
- No stalls or handshakes: the block accepts every input every cycle; conflict avoidance is the issuer's job.

Decomposition:
- Shared package commit_pkg holds:
  - XLEN/NREG defaults;
  - the reg_addr_t typedef;
  - the ZERO_REG constant;
  - a popcount function.
- One natural sub-module, wb_bypass_mux:
  - per read port, priority-select over the NUM_WB write ports;
  - returns data and a hit flag;
  - instantiated NUM_RD times;
  - the hit flag serves both rd_data selection and rd_busy masking.

Test Plan:
- Reset, then read addrs 5 and 31 → rd_data 0, rd_busy 0, instret 0; hold reset with wb_valid=2'b11 → no register changes.
- Write x5=0xDEAD_BEEF on port 0; same cycle read x5 → 0xDEAD_BEEF (bypass); next cycle still 0xDEAD_BEEF from storage.
- Ports 0 and 1 both write x7 (0x1111, 0x2222) → same-cycle read returns 0x2222; stored value 0x2222.
- Write 0x55 to x0 and issue to x0 → reads of x0 return 0, busy 0.
- Issue x9 → next cycle rd_busy=1; cycle with wb x9=0x42 → rd_busy 0 and data 0x42; issue x9 plus wb x9 together → busy 1 afterwards; then flush → busy 0.
- commit_valid=2'b11 for 3 cycles, then 2'b01 → instret=7; preload instret near 2^CNT_W−1 (CNT_W=4 build: 15 + 2) → wraps to 1.

Source files
------------

// File: rtl/commit_regfile_mp_pkg.sv
// Shared types and helpers for the commit-stage register file.
package commit_pkg;
  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int ZERO_REG = 0;
  localparam int POP_MAX  = 32;

  typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX; i++) c += 32'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/commit_regfile_mp_if.sv
// Read/issue/write-back/commit bus of the commit register file.
interface commit_regfile_mp_if #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WB = 2,
  parameter int CNT_W  = 64
);
  localparam int AW = $clog2(NREG);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   issue_valid;
  logic [AW-1:0]          issue_rd;
  logic                   flush;
  logic [NUM_WB-1:0]      wb_valid;
  logic [NUM_WB*AW-1:0]   wb_addr;
  logic [NUM_WB*XLEN-1:0] wb_data;
  logic [NUM_WB-1:0]      commit_valid;
  logic [CNT_W-1:0]       instret;

  modport master (
    output rd_addr, issue_valid, issue_rd, flush, wb_valid, wb_addr, wb_data, commit_valid,
    input  rd_data, rd_busy, instret
  );
  modport slave (
    input  rd_addr, issue_valid, issue_rd, flush, wb_valid, wb_addr, wb_data, commit_valid,
    output rd_data, rd_busy, instret
  );
endinterface

// File: rtl/commit_regfile_mp_wb_bypass_mux.sv
// Per-read-port forwarding: highest-index matching write-back port wins over storage.
module wb_bypass_mux
  import commit_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int AW     = 5,
  parameter int NUM_WB = 2
) (
  input  logic [AW-1:0]                 rd_addr,
  input  logic [XLEN-1:0]               reg_data,
  input  logic [NUM_WB-1:0]             wb_valid,
  input  logic [NUM_WB-1:0][AW-1:0]     wb_addr,
  input  logic [NUM_WB-1:0][XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]               data,
  output logic                          hit
);
  always_comb begin
    data = reg_data;
    hit  = 1'b0;
    // ascending scan so a later (higher-priority) port overrides
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i] && wb_addr[i] == rd_addr && wb_addr[i] != AW'(ZERO_REG)) begin
        data = wb_data[i];
        hit  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/commit_regfile_mp.sv
// Architectural register file with bypassed reads, busy scoreboard and retire counter.
module commit_regfile_mp
  import commit_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int AW     = $clog2(NREG),
  parameter int NUM_RD = 2,
  parameter int NUM_WB = 2,
  parameter int CNT_W  = 64
) (
  input  logic clock,
  input  logic reset,
  commit_regfile_mp_if.slave bus
);
  localparam int PC_W = $clog2(NUM_WB + 1);

  logic [NREG-1:0][XLEN-1:0]   regs;
  logic [NREG-1:0]             busy, busy_nxt, wb_tgt;
  logic [NUM_WB-1:0][AW-1:0]   wa;
  logic [NUM_WB-1:0][XLEN-1:0] wd;
  logic [NUM_RD-1:0][AW-1:0]   ra;
  logic [NUM_RD-1:0][XLEN-1:0] rdat;
  logic [NUM_RD-1:0]           rhit, rbusy;
  logic [PC_W-1:0]             pc;
  logic [CNT_W-1:0]            instret_q;

  assign wa = bus.wb_addr;
  assign wd = bus.wb_data;
  assign ra = bus.rd_addr;
  assign pc = PC_W'(popcount(POP_MAX'(bus.commit_valid)));

  always_comb begin
    wb_tgt = '0;
    for (int i = 0; i < NUM_WB; i++)
      if (bus.wb_valid[i]) wb_tgt[wa[i]] = 1'b1;
  end

  // issue beats write-back (new producer owns r); flush beats both
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NREG; r++) begin
      if (bus.issue_valid && bus.issue_rd == AW'(r) && !bus.flush) busy_nxt[r] = 1'b1;
      else if (wb_tgt[r] || bus.flush)                            busy_nxt[r] = 1'b0;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regs      <= '0;
      busy      <= '0;
      instret_q <= '0;
    end else begin
      for (int i = 0; i < NUM_WB; i++)
        if (bus.wb_valid[i] && wa[i] != AW'(ZERO_REG)) regs[wa[i]] <= wd[i];
      busy      <= busy_nxt;
      instret_q <= instret_q + CNT_W'(pc);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    wb_bypass_mux #(.XLEN(XLEN), .AW(AW), .NUM_WB(NUM_WB)) u_byp (
      .rd_addr (ra[k]),
      .reg_data(regs[ra[k]]),
      .wb_valid(bus.wb_valid),
      .wb_addr (wa),
      .wb_data (wd),
      .data    (rdat[k]),
      .hit     (rhit[k])
    );
    assign rbusy[k] = busy[ra[k]] & ~rhit[k];
  end

  assign bus.rd_data = rdat;
  assign bus.rd_busy = rbusy;
  assign bus.instret = instret_q;
endmodule
